// File: rtl/seg_scan_display_n_pkg.sv
// Shared types and constants for the multiplexed 7-segment scanner and its
// code decoder: digit code encoding and active-low segment patterns.
package seg_scan_display_n_pkg;

  localparam int unsigned CODE_W = 5;
  localparam int unsigned SEG_W  = 8;
  localparam int unsigned PWM_W  = 4;

  typedef logic [CODE_W-1:0] code_t;
  typedef logic [SEG_W-1:0]  seg_t;

  localparam code_t CODE_DASH  = 5'd16;
  localparam code_t CODE_BLANK = 5'd17;

  // Active-low patterns, bit 7 = dp, bits 6:0 = g..a
  localparam seg_t SEG_0     = 8'hC0;
  localparam seg_t SEG_1     = 8'hF9;
  localparam seg_t SEG_2     = 8'hA4;
  localparam seg_t SEG_3     = 8'hB0;
  localparam seg_t SEG_4     = 8'h99;
  localparam seg_t SEG_5     = 8'h92;
  localparam seg_t SEG_6     = 8'h82;
  localparam seg_t SEG_7     = 8'hF8;
  localparam seg_t SEG_8     = 8'h80;
  localparam seg_t SEG_9     = 8'h90;
  localparam seg_t SEG_A     = 8'h88;
  localparam seg_t SEG_B     = 8'h83;
  localparam seg_t SEG_C     = 8'hC6;
  localparam seg_t SEG_D     = 8'hA1;
  localparam seg_t SEG_E     = 8'h86;
  localparam seg_t SEG_F     = 8'h8E;
  localparam seg_t SEG_DASH  = 8'hBF;
  localparam seg_t SEG_BLANK = 8'hFF;

  // One shadowed digit: its code plus per-digit decimal point and blink enable
  typedef struct packed {
    code_t code;
    logic  dp;
    logic  blink;
  } digit_cfg_t;

  function automatic seg_t hex_to_seg(input logic [3:0] nib);
    seg_t s;
    s = SEG_BLANK;
    case (nib)
      4'h0: s = SEG_0;
      4'h1: s = SEG_1;
      4'h2: s = SEG_2;
      4'h3: s = SEG_3;
      4'h4: s = SEG_4;
      4'h5: s = SEG_5;
      4'h6: s = SEG_6;
      4'h7: s = SEG_7;
      4'h8: s = SEG_8;
      4'h9: s = SEG_9;
      4'hA: s = SEG_A;
      4'hB: s = SEG_B;
      4'hC: s = SEG_C;
      4'hD: s = SEG_D;
      4'hE: s = SEG_E;
      4'hF: s = SEG_F;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg_scan_display_n_if.sv
// Front-panel display bus: digit data and load handshake from the controller,
// scan outputs toward the LED digit/segment drivers.
interface seg_scan_display_n_if
  import seg_scan_display_n_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 8
) ();

  logic                         enable;
  logic [NUM_DIGITS*CODE_W-1:0] digit_code;
  logic [NUM_DIGITS-1:0]        dp_mask;
  logic [NUM_DIGITS-1:0]        blink_mask;
  logic [PWM_W-1:0]             brightness;
  logic                         load;
  logic                         load_ack;
  logic                         frame_start;
  logic [NUM_DIGITS-1:0]        bit_select;
  seg_t                         seg_select;

  modport master (
    output enable, digit_code, dp_mask, blink_mask, brightness, load,
    input  load_ack, frame_start, bit_select, seg_select
  );

  modport slave (
    input  enable, digit_code, dp_mask, blink_mask, brightness, load,
    output load_ack, frame_start, bit_select, seg_select
  );

endinterface

// File: rtl/seg_code_decoder.sv
// Digit code to active-low 7-segment pattern (hex, dash, blank) with
// decimal point overlay; also used by the status-LED block.
module seg_code_decoder
  import seg_scan_display_n_pkg::*;
(
  input  code_t code,
  input  logic  dp,
  output seg_t  seg_c
);

  seg_t base_c;

  always_comb begin
    base_c = SEG_BLANK;
    if (code < CODE_DASH) begin
      base_c = hex_to_seg(code[3:0]);
    end else if (code == CODE_DASH) begin
      base_c = SEG_DASH;
    end
    seg_c = base_c;
    if (dp) begin
      seg_c[SEG_W-1] = 1'b0;
    end
  end

endmodule

// File: rtl/seg_scan_display_n.sv
// Multiplexed 7-segment scanner: frame-synchronous shadow load, per-digit
// dp/blink, 16-level brightness PWM and a blanking window at each slot start.
module seg_scan_display_n
  import seg_scan_display_n_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned SCAN_DIV     = 100000,
  parameter int unsigned BLANK_CYC    = 16,
  parameter int unsigned BLINK_FRAMES = 50
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  seg_scan_display_n_if.slave   bus
);

  localparam int unsigned IDX_W   = $clog2(NUM_DIGITS);
  localparam int unsigned SLOT_W  = $clog2(SCAN_DIV);
  localparam int unsigned FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [SLOT_W-1:0]  slot_cnt;
  logic [IDX_W-1:0]   digit_idx;
  logic [PWM_W-1:0]   pwm_cnt;
  logic [FRAME_W-1:0] frame_cnt;
  logic               blink_on;
  logic               load_pending;
  digit_cfg_t         shadow [NUM_DIGITS];

  logic       tick_c;
  logic       boundary_c;
  logic       capture_c;
  logic       lit_c;
  digit_cfg_t cur_c;
  seg_t       seg_c;

  // Slot/frame events, shadow capture and the lit decision for the current digit
  always_comb begin
    tick_c     = bus.enable && (slot_cnt == SLOT_W'(SCAN_DIV - 1));
    boundary_c = tick_c && (digit_idx == IDX_W'(NUM_DIGITS - 1));
    capture_c  = (bus.load || load_pending) && (boundary_c || !bus.enable);
    cur_c      = shadow[digit_idx];
    lit_c      = bus.enable
              && (slot_cnt >= SLOT_W'(BLANK_CYC))
              && (pwm_cnt <= bus.brightness)
              && !(cur_c.blink && !blink_on);
  end

  seg_code_decoder u_decoder (
    .code  (cur_c.code),
    .dp    (cur_c.dp),
    .seg_c (seg_c)
  );

  // Scan counters; a disabled display parks at digit 0 with blink phase on
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      slot_cnt        <= '0;
      digit_idx       <= '0;
      pwm_cnt         <= '0;
      frame_cnt       <= '0;
      blink_on        <= 1'b1;
      bus.frame_start <= 1'b0;
    end else begin
      pwm_cnt         <= pwm_cnt + PWM_W'(1);
      bus.frame_start <= boundary_c;
      if (!bus.enable) begin
        slot_cnt  <= '0;
        digit_idx <= '0;
        frame_cnt <= '0;
        blink_on  <= 1'b1;
      end else begin
        slot_cnt <= tick_c ? '0 : slot_cnt + SLOT_W'(1);
        if (tick_c) begin
          digit_idx <= boundary_c ? '0 : digit_idx + IDX_W'(1);
        end
        if (boundary_c) begin
          if (frame_cnt == FRAME_W'(BLINK_FRAMES - 1)) begin
            frame_cnt <= '0;
            blink_on  <= ~blink_on;
          end else begin
            frame_cnt <= frame_cnt + FRAME_W'(1);
          end
        end
      end
    end
  end

  // Shadow set takes the inputs live at capture time, so merged loads see the latest data
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      load_pending <= 1'b0;
      bus.load_ack <= 1'b0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        shadow[i] <= '{code: CODE_BLANK, dp: 1'b0, blink: 1'b0};
      end
    end else begin
      bus.load_ack <= capture_c;
      if (capture_c) begin
        load_pending <= 1'b0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
          shadow[i] <= '{code:  bus.digit_code[i*CODE_W +: CODE_W],
                         dp:    bus.dp_mask[i],
                         blink: bus.blink_mask[i]};
        end
      end else if (bus.load) begin
        load_pending <= 1'b1;
      end
    end
  end

  // Registered digit and segment drive, both active-low
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      bus.bit_select <= '1;
      bus.seg_select <= SEG_BLANK;
    end else if (lit_c) begin
      bus.bit_select <= ~(NUM_DIGITS'(1) << digit_idx);
      bus.seg_select <= seg_c;
    end else begin
      bus.bit_select <= '1;
      bus.seg_select <= SEG_BLANK;
    end
  end

endmodule

// File: tb/tb_seg_scan_display_n.sv
// Scoreboard bench for seg_scan_display_n: 4 digits, 8-cycle slots, 2-cycle
// blank, 2-frame blink; expectations are stamped with the cycle they are due.
module tb_seg_scan_display_n;
  import seg_scan_display_n_pkg::*;

  localparam int unsigned ND = 4;
  localparam int K_DISP = 0;
  localparam int K_ACK  = 1;
  localparam int K_FS   = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  seg_scan_display_n_if #(.NUM_DIGITS(ND)) bus ();

  seg_scan_display_n #(
    .NUM_DIGITS  (ND),
    .SCAN_DIV    (8),
    .BLANK_CYC   (2),
    .BLINK_FRAMES(2)
  ) dut (
    .sys_clk  (clk),
    .sys_rst_n(rst_n),
    .bus      (bus)
  );

  typedef struct {
    int unsigned at;
    int          kind;
    logic [11:0] val;
    string       name;
  } sb_item_t;

  sb_item_t    sb[$];
  int unsigned gcyc  = 0;
  int unsigned g0    = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) gcyc <= gcyc + 1;

  // Expected item due at cycle k after the last reset release, kept time-ordered
  function automatic void push(input int unsigned k, input int kind,
                               input logic [11:0] v, input string nm);
    sb_item_t it_n;
    int pos;
    it_n.at   = g0 + k;
    it_n.kind = kind;
    it_n.val  = v;
    it_n.name = nm;
    pos = sb.size();
    while (pos > 0 && sb[pos-1].at > it_n.at) pos--;
    sb.insert(pos, it_n);
  endfunction

  function automatic void disp(input int unsigned k, input logic [3:0] bs,
                               input logic [7:0] ss, input string nm);
    push(k, K_DISP, {bs, ss}, nm);
  endfunction

  function automatic void ack(input int unsigned k, input logic v, input string nm);
    push(k, K_ACK, {11'd0, v}, nm);
  endfunction

  function automatic void fs(input int unsigned k, input logic v, input string nm);
    push(k, K_FS, {11'd0, v}, nm);
  endfunction

  task automatic at_cyc(input int unsigned k);
    while (gcyc < g0 + k) @(negedge clk);
  endtask

  // Monitor: pops every item that has come due and compares with the DUT
  sb_item_t    cur;
  logic [11:0] act;
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].at <= gcyc) begin
      cur = sb.pop_front();
      n_cmp++;
      case (cur.kind)
        K_DISP:  act = {bus.bit_select, bus.seg_select};
        K_ACK:   act = {11'd0, bus.load_ack};
        default: act = {11'd0, bus.frame_start};
      endcase
      if (cur.at != gcyc) begin
        n_bad++;
        $display("FAIL %s: due at cycle %0d, seen only at %0d", cur.name, cur.at, gcyc);
      end else if (act !== cur.val) begin
        n_bad++;
        $display("FAIL %s @%0d: got %h, expected %h", cur.name, gcyc - g0, act, cur.val);
      end
    end
  end

  initial begin
    bus.enable     = 1'b1;
    bus.brightness = 4'hF;
    bus.load       = 1'b0;
    bus.dp_mask    = '0;
    bus.blink_mask = '0;
    bus.digit_code = {4{5'd17}};

    disp(2, 4'hF, 8'hFF, "in_reset_dark");
    ack(2, 1'b0, "in_reset_ack");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    g0    = gcyc;

    // Blank shadow after reset, then basic scan of {3,2,1,0}
    disp(1, 4'hF, 8'hFF, "first_slot_blank_window");
    disp(3, 4'hE, 8'hFF, "blank_shadow_digit0");
    ack(6, 1'b0, "no_ack_mid_frame");
    fs(31, 1'b0, "fs_before_boundary");
    ack(31, 1'b0, "ack_before_boundary");
    fs(32, 1'b1, "fs_frame1");
    ack(32, 1'b1, "ack_basic_load");
    ack(33, 1'b0, "ack_single_pulse");
    disp(33, 4'hF, 8'hFF, "d0_blank_cyc1");
    disp(34, 4'hF, 8'hFF, "d0_blank_cyc2");
    disp(35, 4'hE, 8'hC0, "d0_first_lit");
    disp(40, 4'hE, 8'hC0, "d0_last_lit");
    disp(43, 4'hD, 8'hF9, "d1_code1");
    disp(51, 4'hB, 8'hA4, "d2_code2");
    disp(59, 4'h7, 8'hB0, "d3_code3");
    fs(63, 1'b0, "fs_gap");
    fs(64, 1'b1, "fs_frame2");
    disp(64, 4'h7, 8'hB0, "d3_slot_end");
    disp(65, 4'hF, 8'hFF, "d0_blank_frame3");
    at_cyc(5);
    bus.digit_code = {5'd3, 5'd2, 5'd1, 5'd0};
    bus.load       = 1'b1;
    at_cyc(6);
    bus.load = 1'b0;

    // Special codes: blank, dash, 9, 0 with dp
    at_cyc(66);
    disp(67, 4'hE, 8'hC0, "shadow_held_until_boundary");
    ack(95, 1'b0, "special_no_early_ack");
    ack(96, 1'b1, "special_ack");
    disp(99, 4'hE, 8'h40, "d0_zero_dp");
    disp(107, 4'hD, 8'h90, "d1_nine");
    disp(115, 4'hB, 8'hBF, "d2_dash");
    disp(123, 4'h7, 8'hFF, "d3_blank_code20");
    bus.digit_code = {5'd20, 5'd16, 5'd9, 5'd0};
    bus.dp_mask    = 4'b0001;
    bus.load       = 1'b1;
    at_cyc(67);
    bus.load = 1'b0;

    // Blink digit1: lit frame 5, dark frames 6-7, lit frame 8
    at_cyc(130);
    ack(160, 1'b1, "blink_ack");
    ack(161, 1'b0, "blink_ack_single");
    disp(171, 4'hD, 8'h90, "blink_on_d1");
    disp(195, 4'hE, 8'h40, "blink_d0_unaffected");
    disp(203, 4'hF, 8'hFF, "blink_off_d1_a");
    disp(211, 4'hB, 8'hBF, "blink_d2_unaffected");
    disp(235, 4'hF, 8'hFF, "blink_off_d1_b");
    disp(267, 4'hD, 8'h90, "blink_on_again_d1");
    bus.blink_mask = 4'b0010;
    bus.load       = 1'b1;
    at_cyc(131);
    bus.load = 1'b0;

    // Two loads in one frame merge; the second data set wins
    at_cyc(290);
    for (int unsigned k = 291; k <= 319; k++) ack(k, 1'b0, "merged_no_early_ack");
    ack(320, 1'b1, "merged_single_ack");
    for (int unsigned k = 321; k <= 325; k++) ack(k, 1'b0, "merged_no_second_ack");
    disp(323, 4'hE, 8'h88, "merged_second_data_d0");
    disp(331, 4'hD, 8'hFF, "merged_second_data_d1");
    bus.digit_code = {5'd17, 5'd17, 5'd17, 5'd7};
    bus.dp_mask    = '0;
    bus.blink_mask = '0;
    bus.load       = 1'b1;
    at_cyc(291);
    bus.load = 1'b0;
    at_cyc(293);
    bus.digit_code = {5'd17, 5'd17, 5'd17, 5'd10};
    bus.load       = 1'b1;
    at_cyc(294);
    bus.load = 1'b0;

    // Brightness 3: lit only while pwm_cnt <= 3
    at_cyc(352);
    disp(355, 4'hE, 8'h88, "pwm2_lit");
    disp(356, 4'hE, 8'h88, "pwm3_lit");
    disp(357, 4'hF, 8'hFF, "pwm4_dark");
    disp(360, 4'hF, 8'hFF, "pwm7_dark");
    disp(371, 4'hB, 8'hFF, "pwm2_d2_lit");
    disp(373, 4'hF, 8'hFF, "pwm4_d2_dark");
    bus.brightness = 4'd3;

    // Disabled: dark, immediate load; re-enable restarts at digit 0
    at_cyc(400);
    disp(401, 4'hF, 8'hFF, "disabled_dark");
    disp(403, 4'hF, 8'hFF, "disabled_dark2");
    ack(405, 1'b0, "disabled_ack_idle");
    ack(406, 1'b1, "disabled_ack_fast");
    ack(407, 1'b0, "disabled_ack_single");
    disp(408, 4'hF, 8'hFF, "disabled_dark_after_load");
    fs(411, 1'b0, "no_fs_on_restart");
    disp(413, 4'hE, 8'h92, "restart_d0_first");
    disp(421, 4'hD, 8'h80, "restart_d1");
    fs(441, 1'b0, "restart_fs_gap");
    fs(442, 1'b1, "restart_first_fs");
    disp(445, 4'hE, 8'h92, "before_async_reset");
    disp(446, 4'hF, 8'hFF, "async_reset_dark");
    ack(446, 1'b0, "async_reset_ack");
    bus.enable     = 1'b0;
    bus.brightness = 4'hF;
    at_cyc(405);
    bus.digit_code = {5'd17, 5'd17, 5'd8, 5'd5};
    bus.load       = 1'b1;
    at_cyc(406);
    bus.load = 1'b0;
    at_cyc(410);
    bus.enable = 1'b1;

    // Mid-slot reset between edges, then shadow must be blank again
    at_cyc(445);
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    g0    = gcyc;
    disp(1, 4'hF, 8'hFF, "post_reset_blank_window");
    disp(3, 4'hE, 8'hFF, "post_reset_shadow_blank");
    ack(3, 1'b0, "post_reset_no_ack");
    at_cyc(10);

    for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d checks never reached, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
